alu_op_sequencer: RTL and testbench

//  Initiator/driver side of the n-bit ALU interface: accepts operation commands over a

---
 rtl/alu_op_sequencer_if.sv | 53 +++++
 rtl/alu_op_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response signals for alu_op_sequencer.
// slave is the sequencer's view; master is the host/ALU side.
interface alu_op_sequencer_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CountW = $clog2(DEPTH) + 1;

   // Command channel
   logic              cmd_valid;
   logic              cmd_ready;
   logic [N-1:0]      cmd_a;
   logic [N-1:0]      cmd_b;
   logic [2:0]        cmd_mode;
   logic              cmd_cin;

   // ALU drive and capture
   logic [N-1:0]      alu_a;
   logic [N-1:0]      alu_b;
   logic [2:0]        alu_mode;
   logic              alu_cin;
   logic [N-1:0]      alu_result;
   logic              alu_cout;

   // Response channel and status
   logic              rsp_valid;
   logic              rsp_ready;
   logic [N-1:0]      rsp_result;
   logic              rsp_cout;
   logic [2:0]        rsp_mode;
   logic              busy;
   logic [CountW-1:0] rsp_count;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_cin,
      output cmd_ready,
      output alu_a, alu_b, alu_mode, alu_cin,
      input  alu_result, alu_cout,
      output rsp_valid, rsp_result, rsp_cout, rsp_mode,
      input  rsp_ready,
      output busy, rsp_count
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_cin,
      input  cmd_ready,
      input  alu_a, alu_b, alu_mode, alu_cin,
      output alu_result, alu_cout,
      input  rsp_valid, rsp_result, rsp_cout, rsp_mode,
      output rsp_ready,
      input  busy, rsp_count
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives one command at a time into a combinational ALU, waits SETTLE cycles,
// then captures the ALU outputs into a first-word-fall-through response FIFO.
module alu_op_sequencer #(
   parameter int unsigned N      = 4,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned DEPTH  = 4
) (
   input logic               clk,
   input logic               rst_n,
   alu_op_sequencer_if.slave bus
);
   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned CountW = PtrW + 1;
   localparam int unsigned WaitW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [WaitW-1:0]  WaitInit  = WaitW'(SETTLE - 1);
   localparam logic [CountW-1:0] CountFull = CountW'(DEPTH);

   typedef enum logic {StIdle, StWait} state_e;

   state_e            state_q;
   logic [WaitW-1:0]  wait_cnt_q;
   logic [N-1:0]      alu_a_q;
   logic [N-1:0]      alu_b_q;
   logic [2:0]        alu_mode_q;
   logic              alu_cin_q;

   logic [N-1:0]      mem_result [DEPTH];
   logic              mem_cout   [DEPTH];
   logic [2:0]        mem_mode   [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q;
   logic [PtrW-1:0]   rd_ptr_q;
   logic [CountW-1:0] count_q;

   // Values of the most recently popped entry, shown while the FIFO is empty
   logic [N-1:0]      last_result_q;
   logic              last_cout_q;
   logic [2:0]        last_mode_q;

   logic              cmd_ready;
   logic              accept;
   logic              push;
   logic              pop;
   logic              not_empty;

   assign not_empty = (count_q != '0);
   assign cmd_ready = (state_q == StIdle) && (count_q < CountFull);
   assign accept    = bus.cmd_valid && cmd_ready;
   assign push      = (state_q == StWait) && (wait_cnt_q == '0);
   assign pop       = not_empty && bus.rsp_ready;

   // Command FSM: latch operands on accept, count down the settle time, then release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_mode_q <= '0;
         alu_cin_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  alu_a_q    <= bus.cmd_a;
                  alu_b_q    <= bus.cmd_b;
                  alu_mode_q <= bus.cmd_mode;
                  alu_cin_q  <= bus.cmd_cin;
                  wait_cnt_q <= WaitInit;
                  state_q    <= StWait;
               end
            end
            StWait: begin
               if (wait_cnt_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  wait_cnt_q <= wait_cnt_q - WaitW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // FIFO storage; contents only matter below the occupancy count, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_result[wr_ptr_q] <= bus.alu_result;
         mem_cout[wr_ptr_q]   <= bus.alu_cout;
         mem_mode[wr_ptr_q]   <= alu_mode_q;
      end
   end

   // FIFO pointers, occupancy and last-popped holding registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         last_result_q <= '0;
         last_cout_q   <= 1'b0;
         last_mode_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q      <= rd_ptr_q + PtrW'(1);
            last_result_q <= mem_result[rd_ptr_q];
            last_cout_q   <= mem_cout[rd_ptr_q];
            last_mode_q   <= mem_mode[rd_ptr_q];
         end
         // Simultaneous push and pop leaves occupancy unchanged
         if (push && !pop) begin
            count_q <= count_q + CountW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CountW'(1);
         end
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_mode   = alu_mode_q;
   assign bus.alu_cin    = alu_cin_q;
   assign bus.busy       = (state_q == StWait);
   assign bus.rsp_count  = count_q;
   assign bus.rsp_valid  = not_empty;
   assign bus.rsp_result = not_empty ? mem_result[rd_ptr_q] : last_result_q;
   assign bus.rsp_cout   = not_empty ? mem_cout[rd_ptr_q]   : last_cout_q;
   assign bus.rsp_mode   = not_empty ? mem_mode[rd_ptr_q]   : last_mode_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with SETTLE=1, one with SETTLE=3,
// each driving a behavioural ALU model.
module tb_alu_op_sequencer;
   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] mode;
      logic       cin;
      logic [3:0] res;
      logic       cout;
   } vec_t;

   logic clk;
   logic rst_n1;
   logic rst_n3;
   int   checks;
   int   errors;

   alu_op_sequencer_if #(.N(4), .DEPTH(4)) h1 ();
   alu_op_sequencer_if #(.N(4), .DEPTH(4)) h3 ();

   alu_op_sequencer #(.N(4), .SETTLE(1), .DEPTH(4)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n1),
      .bus   (h1)
   );

   alu_op_sequencer #(.N(4), .SETTLE(3), .DEPTH(4)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n3),
      .bus   (h3)
   );

   // ALU model: mode 0 add, 1 add-inverted-B, 2 and, 3 or, 4 xor, 5 not A, 6 pass A, 7 pass B
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] m, input logic c);
      case (m)
         3'd0:    alu_f = {1'b0, a} + {1'b0, b} + {4'b0, c};
         3'd1:    alu_f = {1'b0, a} + {1'b0, ~b} + {4'b0, c};
         3'd2:    alu_f = {1'b0, a & b};
         3'd3:    alu_f = {1'b0, a | b};
         3'd4:    alu_f = {1'b0, a ^ b};
         3'd5:    alu_f = {1'b0, ~a};
         3'd6:    alu_f = {1'b0, a};
         default: alu_f = {1'b0, b};
      endcase
   endfunction

   assign {h1.alu_cout, h1.alu_result} = alu_f(h1.alu_a, h1.alu_b, h1.alu_mode, h1.alu_cin);
   assign {h3.alu_cout, h3.alu_result} = alu_f(h3.alu_a, h3.alu_b, h3.alu_mode, h3.alu_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_cmd1(input vec_t v);
      h1.cmd_a    = v.a;
      h1.cmd_b    = v.b;
      h1.cmd_mode = v.mode;
      h1.cmd_cin  = v.cin;
   endtask

   // Offer a command to dut1; returns 1 ns after the accepting edge
   task automatic send1(input vec_t v);
      logic ok;
      ok = 1'b0;
      set_cmd1(v);
      h1.cmd_valid = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = h1.cmd_ready;
         @(posedge clk);
         #1;
      end
      h1.cmd_valid = 1'b0;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // Wait for a dut1 response, compare it with v, then pop it
   task automatic pop_chk1(input vec_t v);
      int c;
      c = 0;
      @(negedge clk);
      while (!h1.rsp_valid && c < 10) begin
         @(negedge clk);
         c++;
      end
      chk("pop_valid",  h1.rsp_valid,  1);
      chk("pop_result", h1.rsp_result, v.res);
      chk("pop_cout",   h1.rsp_cout,   v.cout);
      chk("pop_mode",   h1.rsp_mode,   v.mode);
      h1.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      h1.rsp_ready = 1'b0;
   endtask

   vec_t tbl [8];
   vec_t t3  [3];
   vec_t vx;
   vec_t vy;

   initial begin
      checks = 0;
      errors = 0;
      // Hand-computed expected results, cin=0, one per mode
      tbl[0] = '{4'b1001, 4'b1010, 3'd0, 1'b0, 4'b0011, 1'b1};
      tbl[1] = '{4'b0111, 4'b0010, 3'd1, 1'b0, 4'b0100, 1'b1};
      tbl[2] = '{4'b1100, 4'b1010, 3'd2, 1'b0, 4'b1000, 1'b0};
      tbl[3] = '{4'b0101, 4'b0010, 3'd3, 1'b0, 4'b0111, 1'b0};
      tbl[4] = '{4'b1111, 4'b0110, 3'd4, 1'b0, 4'b1001, 1'b0};
      tbl[5] = '{4'b0011, 4'b0001, 3'd5, 1'b0, 4'b1100, 1'b0};
      tbl[6] = '{4'b1010, 4'b0100, 3'd6, 1'b0, 4'b1010, 1'b0};
      tbl[7] = '{4'b0001, 4'b1110, 3'd7, 1'b0, 4'b1110, 1'b0};
      t3[0]  = '{4'b0111, 4'b1000, 3'd0, 1'b1, 4'b0000, 1'b1};
      t3[1]  = '{4'b0011, 4'b0100, 3'd0, 1'b1, 4'b1000, 1'b0};
      t3[2]  = '{4'b1111, 4'b1111, 3'd0, 1'b1, 4'b1111, 1'b1};
      vx     = '{4'b0110, 4'b0011, 3'd0, 1'b0, 4'b1001, 1'b0};
      vy     = '{4'b1000, 4'b1001, 3'd0, 1'b1, 4'b0010, 1'b1};

      h1.cmd_valid = 1'b0; h1.rsp_ready = 1'b0; set_cmd1(tbl[0]);
      h3.cmd_valid = 1'b0; h3.rsp_ready = 1'b0;
      h3.cmd_a = '0; h3.cmd_b = '0; h3.cmd_mode = '0; h3.cmd_cin = 1'b0;
      rst_n1 = 1'b0;
      rst_n3 = 1'b0;
      #12;
      // Reset state
      chk("rst_cmd_ready", h1.cmd_ready, 1);
      chk("rst_busy",      h1.busy,      0);
      chk("rst_rsp_valid", h1.rsp_valid, 0);
      chk("rst_count",     h1.rsp_count, 0);
      chk("rst_alu_a",     h1.alu_a,     0);
      chk("rst_rsp_res",   h1.rsp_result, 0);
      rst_n1 = 1'b1;
      rst_n3 = 1'b1;

      // 1: single op with exact latency
      @(posedge clk); #1;
      set_cmd1(tbl[0]);
      h1.cmd_valid = 1'b1;
      @(negedge clk);
      chk("t1_ready_before", h1.cmd_ready, 1);
      @(posedge clk); #1;
      h1.cmd_valid = 1'b0;
      chk("t1_busy",       h1.busy,      1);
      chk("t1_ready_wait", h1.cmd_ready, 0);
      chk("t1_alu_a",      h1.alu_a,     4'b1001);
      chk("t1_alu_b",      h1.alu_b,     4'b1010);
      chk("t1_valid_early", h1.rsp_valid, 0);
      @(posedge clk); #1;
      chk("t1_valid",   h1.rsp_valid,  1);
      chk("t1_result",  h1.rsp_result, 4'b0011);
      chk("t1_cout",    h1.rsp_cout,   1);
      chk("t1_mode",    h1.rsp_mode,   0);
      chk("t1_ready",   h1.cmd_ready,  1);
      chk("t1_idle",    h1.busy,       0);
      chk("t1_count",   h1.rsp_count,  1);
      h1.rsp_ready = 1'b1;
      @(posedge clk); #1;
      h1.rsp_ready = 1'b0;
      chk("t1_count_pop", h1.rsp_count, 0);
      chk("t1_empty",     h1.rsp_valid, 0);

      // 2: backpressure with five back-to-back commands
      begin
         int   acc;
         logic fire;
         acc = 0;
         set_cmd1(tbl[0]);
         h1.cmd_valid = 1'b1;
         for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            fire = h1.cmd_ready;
            @(posedge clk); #1;
            if (fire) begin
               acc++;
               if (acc < 5) set_cmd1(tbl[acc]);
            end
         end
         chk("t2_accepted", acc,           4);
         chk("t2_count",    h1.rsp_count,  4);
         chk("t2_ready",    h1.cmd_ready,  0);
         chk("t2_head",     h1.rsp_result, tbl[0].res);
         h1.rsp_ready = 1'b1;
         @(posedge clk); #1;
         h1.rsp_ready = 1'b0;
         chk("t2_count_pop", h1.rsp_count, 3);
         chk("t2_ready_pop", h1.cmd_ready, 1);
         @(posedge clk); #1;
         h1.cmd_valid = 1'b0;
         chk("t2_fifth_busy", h1.busy, 1);
         @(posedge clk); #1;
         chk("t2_count_refill", h1.rsp_count, 4);
         for (int i = 1; i < 5; i++) pop_chk1(tbl[i]);
         chk("t2_drained", h1.rsp_count, 0);
      end

      // 3: push and pop on the same edge keep occupancy at one
      send1(t3[0]);
      @(posedge clk); #1;
      chk("t3_count_pre", h1.rsp_count, 1);
      for (int j = 1; j < 3; j++) begin
         send1(t3[j]);
         h1.rsp_ready = 1'b1;
         @(negedge clk);
         chk("t3_head_old", h1.rsp_result, t3[j-1].res);
         @(posedge clk); #1;
         h1.rsp_ready = 1'b0;
         chk("t3_count",    h1.rsp_count,  1);
         chk("t3_head_new", h1.rsp_result, t3[j].res);
         chk("t3_cout_new", h1.rsp_cout,   t3[j].cout);
      end
      pop_chk1(t3[2]);

      // 5: ordering across all modes, two batches of four
      for (int i = 0; i < 8; i++) begin
         send1(tbl[i]);
         if (i % 4 == 3) begin
            for (int k = i - 3; k <= i; k++) pop_chk1(tbl[k]);
         end
      end
      chk("t5_empty", h1.rsp_count, 0);

      // 4: reset during WAIT on the SETTLE=3 instance
      @(posedge clk); #1;
      h3.cmd_a = 4'b0101; h3.cmd_b = 4'b0011; h3.cmd_mode = 3'd0; h3.cmd_cin = 1'b1;
      h3.cmd_valid = 1'b1;
      @(posedge clk); #1;
      h3.cmd_valid = 1'b0;
      chk("t4_busy",  h3.busy,  1);
      chk("t4_alu_a", h3.alu_a, 4'b0101);
      @(posedge clk); #1;
      rst_n3 = 1'b0;
      #1;
      chk("t4_rst_busy",  h3.busy,      0);
      chk("t4_rst_valid", h3.rsp_valid, 0);
      chk("t4_rst_count", h3.rsp_count, 0);
      chk("t4_rst_alu",   {h3.alu_a, h3.alu_b, h3.alu_mode, h3.alu_cin}, 0);
      chk("t4_rst_ready", h3.cmd_ready, 1);
      @(negedge clk);
      rst_n3 = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("t4_no_rsp",   h3.rsp_valid, 0);
      chk("t4_no_count", h3.rsp_count, 0);

      // 6: command changes during WAIT are ignored until the next accept
      @(posedge clk); #1;
      h3.cmd_a = vx.a; h3.cmd_b = vx.b; h3.cmd_mode = vx.mode; h3.cmd_cin = vx.cin;
      h3.cmd_valid = 1'b1;
      @(posedge clk); #1;
      h3.cmd_a = vy.a; h3.cmd_b = vy.b; h3.cmd_mode = vy.mode; h3.cmd_cin = vy.cin;
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         chk("t6_busy",  h3.busy,      1);
         chk("t6_ready", h3.cmd_ready, 0);
         chk("t6_alu_a", h3.alu_a,     vx.a);
         chk("t6_alu_b", h3.alu_b,     vx.b);
         chk("t6_early", h3.rsp_valid, 0);
      end
      @(negedge clk);
      chk("t6_valid",  h3.rsp_valid,  1);
      chk("t6_res_x",  h3.rsp_result, vx.res);
      chk("t6_idle",   h3.busy,       0);
      chk("t6_hold_a", h3.alu_a,      vx.a);
      @(posedge clk); #1;
      h3.cmd_valid = 1'b0;
      chk("t6_alu_a_y",   h3.alu_a,   vy.a);
      chk("t6_alu_cin_y", h3.alu_cin, vy.cin);
      chk("t6_busy_y",    h3.busy,    1);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_count2", h3.rsp_count,  2);
      chk("t6_head_x", h3.rsp_result, vx.res);
      h3.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("t6_res_y",  h3.rsp_result, vy.res);
      chk("t6_cout_y", h3.rsp_cout,   vy.cout);
      @(posedge clk); #1;
      h3.rsp_ready = 1'b0;
      chk("t6_drained", h3.rsp_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
